// File: rtl/uart_sample_framer.sv
// uart_sample_framer
//
// Buffers 16-bit decimated sigma-delta samples in a small FIFO and streams
// each one to the UART transmitter as a 4-byte frame:
//   sync byte, sample[15:8], sample[7:0], sample[15:8] ^ sample[7:0]
// The FIFO decouples the filter's sample rate from UART throughput. Dropped
// samples and transmitter errors are latched in sticky flags.
//
// Ports:
//   clk          system clock, all logic on its rising edge
//   rstb         asynchronous active-low reset
//   enable       allows new frames to start (a running frame always finishes)
//   sampleData   16-bit sample word
//   sampleValid  single-cycle write strobe for sampleData
//   clearFlags   clears overflow and txFault
//   txBusy       UART transmitter busy
//   txErr        UART transmitter error
//   txSend       single-cycle send strobe to the UART transmitter
//   txData       byte presented to the UART transmitter
//   busy         a frame is in progress
//   fifoCount    current FIFO occupancy
//   overflow     sticky: a sample was dropped because the FIFO was full
//   txFault      sticky: txErr was seen while a frame was in progress

module uart_sample_framer #(
    parameter int         C_UART_DATA_WIDTH = 8,
    parameter int         C_FIFO_DEPTH      = 16,
    parameter logic [7:0] C_SYNC_BYTE       = 8'hA5,
    parameter int         C_ACK_TIMEOUT     = 15
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic                          enable,
    input  logic [15:0]                   sampleData,
    input  logic                          sampleValid,
    input  logic                          clearFlags,
    input  logic                          txBusy,
    input  logic                          txErr,
    output logic                          txSend,
    output logic [C_UART_DATA_WIDTH-1:0]  txData,
    output logic                          busy,
    output logic [$clog2(C_FIFO_DEPTH):0] fifoCount,
    output logic                          overflow,
    output logic                          txFault
);

    localparam int              ADDR_W     = $clog2(C_FIFO_DEPTH);
    localparam logic [ADDR_W:0] FULL_COUNT = C_FIFO_DEPTH[ADDR_W:0];
    localparam logic [7:0]      ACK_LIMIT  = C_ACK_TIMEOUT[7:0];

    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} FramerState;

    FramerState        state;
    FramerState        stateNext;
    logic [1:0]        byteIdx;
    logic [1:0]        byteIdxNext;
    logic [7:0]        ackTimer;
    logic [7:0]        ackTimerNext;
    logic [15:0]       frameReg;
    logic [15:0]       frameRegNext;
    logic [7:0]        byteNext;
    logic              fifoFull;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] wrPtr;
    logic [ADDR_W-1:0] rdPtr;
    logic [15:0]       fifoMem [C_FIFO_DEPTH];

    // Full is judged on the registered count only, so a pop in the same
    // cycle never makes room for a write that arrives while full.
    assign fifoFull = (fifoCount == FULL_COUNT);
    assign push     = sampleValid && !fifoFull;
    assign busy     = (state != IDLE);

    // Next-state logic. The head of the FIFO is copied into the frame
    // register on the pop, so the FIFO slot is free as soon as a frame starts.
    // WAIT_ACK counts cycles without txBusy and re-sends the same byte when
    // the limit is reached; there is no retry limit.
    always_comb begin
        stateNext    = state;
        byteIdxNext  = byteIdx;
        ackTimerNext = ackTimer;
        frameRegNext = frameReg;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                if (enable && (fifoCount != '0)) begin
                    pop          = 1'b1;
                    frameRegNext = fifoMem[rdPtr];
                    byteIdxNext  = 2'd0;
                    stateNext    = SEND;
                end
            end
            SEND: begin
                ackTimerNext = 8'd0;
                stateNext    = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (txBusy) begin
                    stateNext = WAIT_DONE;
                end else begin
                    ackTimerNext = ackTimer + 8'd1;
                    if (ackTimerNext == ACK_LIMIT) begin
                        stateNext = SEND;
                    end
                end
            end
            WAIT_DONE: begin
                if (!txBusy) begin
                    if (byteIdx != 2'd3) begin
                        byteIdxNext = byteIdx + 2'd1;
                        stateNext   = SEND;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Byte that will be on txData when the machine next enters SEND. Using
    // the next-state values lets txSend/txData be plain registers that line
    // up exactly with the SEND state.
    always_comb begin
        byteNext = C_SYNC_BYTE;
        case (byteIdxNext)
            2'd0:    byteNext = C_SYNC_BYTE;
            2'd1:    byteNext = frameRegNext[15:8];
            2'd2:    byteNext = frameRegNext[7:0];
            default: byteNext = frameRegNext[15:8] ^ frameRegNext[7:0];
        endcase
    end

    // Sample storage. The array is not reset; resetting the pointers and the
    // count is enough to discard its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtr] <= sampleData;
        end
    end

    // State, frame, FIFO bookkeeping, registered UART outputs and sticky
    // flags. On the flags a set event in the same cycle beats clearFlags.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            byteIdx   <= 2'd0;
            ackTimer  <= 8'd0;
            frameReg  <= 16'd0;
            txSend    <= 1'b0;
            txData    <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            overflow  <= 1'b0;
            txFault   <= 1'b0;
        end else begin
            state    <= stateNext;
            byteIdx  <= byteIdxNext;
            ackTimer <= ackTimerNext;
            frameReg <= frameRegNext;
            txSend   <= (stateNext == SEND);
            if (stateNext == SEND) begin
                txData <= C_UART_DATA_WIDTH'(byteNext);
            end
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (push && !pop) begin
                fifoCount <= fifoCount + 1'b1;
            end else if (pop && !push) begin
                fifoCount <= fifoCount - 1'b1;
            end
            if (sampleValid && fifoFull) begin
                overflow <= 1'b1;
            end else if (clearFlags) begin
                overflow <= 1'b0;
            end
            if (txErr && (state != IDLE)) begin
                txFault <= 1'b1;
            end else if (clearFlags) begin
                txFault <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_sample_framer.sv
// tb_uart_sample_framer
//
// Self-checking bench for uart_sample_framer. A transaction-level model keeps
// a sample queue, the expected frame bytes and the sticky flags; a monitor
// compares the DUT against it every cycle and also plays the UART transmitter
// (raising txBusy for a few cycles after each txSend, or never when acks are
// withheld). Directed sequences add literal expectations for single frame,
// overflow, ack timeout, reset mid-frame, simultaneous push/pop and errors.

`timescale 1ns/1ps

module tb_uart_sample_framer;

    localparam int         DEPTH   = 16;
    localparam int         TIMEOUT = 15;
    localparam logic [7:0] SYNC    = 8'hA5;

    logic        clk = 1'b0;
    logic        rstb;
    logic        enable;
    logic [15:0] sampleData;
    logic        sampleValid;
    logic        clearFlags;
    logic        txBusy;
    logic        txErr;
    logic        txSend;
    logic [7:0]  txData;
    logic        busy;
    logic [4:0]  fifoCount;
    logic        overflow;
    logic        txFault;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] modelQ [$];
    logic [7:0]  frameBytes [4];
    logic [7:0]  sendLog [$];
    logic [7:0]  lastByte      = 8'h00;
    logic        modelOverflow = 1'b0;
    logic        modelFault    = 1'b0;
    logic        acked         = 1'b1;
    logic        prevSend      = 1'b0;
    int          framePos      = 0;
    int          sendCount     = 0;
    int          cycleNo       = 0;
    int          lastSendCycle = 0;
    int          prevSendCycle = 0;
    logic        ackEnabled    = 1'b1;
    int          busyLen       = 4;
    int          busyCnt       = 0;

    uart_sample_framer #(
        .C_UART_DATA_WIDTH(8),
        .C_FIFO_DEPTH(DEPTH),
        .C_SYNC_BYTE(SYNC),
        .C_ACK_TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rstb(rstb),
        .enable(enable),
        .sampleData(sampleData),
        .sampleValid(sampleValid),
        .clearFlags(clearFlags),
        .txBusy(txBusy),
        .txErr(txErr),
        .txSend(txSend),
        .txData(txData),
        .busy(busy),
        .fifoCount(fifoCount),
        .overflow(overflow),
        .txFault(txFault)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // One comparison; every miscompare prints a single line.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives every input for the next cycle, changing them on the falling edge.
    task automatic applyStimulus(input logic valid, input logic [15:0] data, input logic en, input logic clr, input logic err);
        @(negedge clk);
        sampleValid = valid;
        sampleData  = data;
        enable      = en;
        clearFlags  = clr;
        txErr       = err;
    endtask

    // Waits until the DUT has issued a given total number of sends.
    task automatic waitSends(input int target, input int budget);
        int n;
        n = 0;
        while (sendCount < target && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (sendCount < target) begin
            checkOutput("sendWait", sendCount, target);
        end
    endtask

    // Waits until the DUT reports no frame in progress.
    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        checkOutput("idleWait", busy, 0);
    endtask

    // Checks four logged send bytes starting at a given send index.
    task automatic checkFrame(input string name, input int start, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        if (sendLog.size() < start + 4) begin
            checkOutput({name, "Len"}, sendLog.size(), start + 4);
        end else begin
            checkOutput({name, "B0"}, sendLog[start], b0);
            checkOutput({name, "B1"}, sendLog[start + 1], b1);
            checkOutput({name, "B2"}, sendLog[start + 2], b2);
            checkOutput({name, "B3"}, sendLog[start + 3], b3);
        end
    endtask

    // Monitor, model and UART transmitter stand-in. Inputs are captured at
    // the rising edge (what the DUT samples), outputs are checked 1 ns later.
    // A send with no txBusy seen since the previous send is a retry of the
    // same byte; otherwise it is the next byte of the frame, and byte 0 means
    // the DUT popped the queue head in the cycle just ended.
    always @(posedge clk) begin
        logic        capValid;
        logic        capClear;
        logic        capErr;
        logic        capBusy;
        logic [15:0] capData;
        logic [15:0] smp;
        logic [7:0]  expByte;
        logic        setOv;
        logic        setFault;
        capValid = sampleValid;
        capData  = sampleData;
        capClear = clearFlags;
        capErr   = txErr;
        capBusy  = txBusy;
        cycleNo++;
        #1;
        if (!rstb) begin
            modelQ.delete();
            modelOverflow = 1'b0;
            modelFault    = 1'b0;
            framePos      = 0;
            acked         = 1'b1;
            prevSend      = 1'b0;
            busyCnt       = 0;
            txBusy        = 1'b0;
            checkOutput("rstTxSend", txSend, 0);
            checkOutput("rstTxData", txData, 0);
            checkOutput("rstBusy", busy, 0);
            checkOutput("rstFifoCount", fifoCount, 0);
        end else begin
            setOv = capValid && (modelQ.size() == DEPTH);
            if (capValid && !setOv) begin
                modelQ.push_back(capData);
            end
            if (setOv) begin
                modelOverflow = 1'b1;
            end else if (capClear) begin
                modelOverflow = 1'b0;
            end
            setFault = capErr && (framePos != 0);
            if (setFault) begin
                modelFault = 1'b1;
            end else if (capClear) begin
                modelFault = 1'b0;
            end
            if (capBusy && !prevSend) begin
                acked = 1'b1;
            end
            if (txSend) begin
                checkOutput("sendPulse", prevSend, 0);
                checkOutput("busyOnSend", busy, 1);
                expByte = lastByte;
                if (acked) begin
                    if (framePos == 0) begin
                        if (modelQ.size() == 0) begin
                            checkOutput("spuriousSend", txSend, 0);
                        end else begin
                            smp = modelQ.pop_front();
                            frameBytes[0] = SYNC;
                            frameBytes[1] = smp[15:8];
                            frameBytes[2] = smp[7:0];
                            frameBytes[3] = smp[15:8] ^ smp[7:0];
                            expByte  = frameBytes[0];
                            framePos = 1;
                        end
                    end else begin
                        expByte  = frameBytes[framePos];
                        framePos = (framePos == 3) ? 0 : framePos + 1;
                    end
                end
                checkOutput("txData", txData, expByte);
                lastByte = expByte;
                acked    = 1'b0;
                sendLog.push_back(txData);
                sendCount++;
                prevSendCycle = lastSendCycle;
                lastSendCycle = cycleNo;
            end
            checkOutput("fifoCount", fifoCount, modelQ.size());
            checkOutput("overflow", overflow, modelOverflow);
            checkOutput("txFault", txFault, modelFault);
            prevSend = txSend;
            if (txSend && ackEnabled) begin
                busyCnt = busyLen;
            end
            if (busyCnt > 0) begin
                txBusy  = 1'b1;
                busyCnt = busyCnt - 1;
            end else begin
                txBusy = 1'b0;
            end
        end
    end

    // Hard stop in case a sequence never returns.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequences with literal expectations.
    initial begin
        int base;
        rstb        = 1'b1;
        enable      = 1'b0;
        sampleData  = 16'h0000;
        sampleValid = 1'b0;
        clearFlags  = 1'b0;
        txErr       = 1'b0;
        txBusy      = 1'b0;
        #2 rstb = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("resetTxSend", txSend, 0);
        checkOutput("resetTxData", txData, 0);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetFifoCount", fifoCount, 0);
        checkOutput("resetOverflow", overflow, 0);
        checkOutput("resetTxFault", txFault, 0);
        @(negedge clk);
        rstb = 1'b1;

        $display("[TB] single frame 0x1234 with first-send latency");
        busyLen = 10;
        base = sendCount;
        applyStimulus(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("latCountN1", fifoCount, 1);
        checkOutput("latSendN1", txSend, 0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("latSendN2", txSend, 1);
        checkOutput("latDataN2", txData, 8'hA5);
        checkOutput("latCountN2", fifoCount, 0);
        waitSends(base + 4, 300);
        waitIdle(100);
        repeat (10) @(posedge clk);
        #2;
        checkOutput("frame1Sends", sendCount - base, 4);
        checkFrame("frame1", base, 8'hA5, 8'h12, 8'h34, 8'h26);
        checkOutput("frame1Busy", busy, 0);
        checkOutput("frame1Count", fifoCount, 0);

        $display("[TB] overflow: 20 writes into a 16-deep FIFO");
        busyLen = 4;
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("ovfCount", fifoCount, 16);
        checkOutput("ovfFlag", overflow, 1);
        base = sendCount;
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        waitSends(base + 64, 3000);
        waitIdle(100);
        repeat (10) @(posedge clk);
        #2;
        checkOutput("ovfSends", sendCount - base, 64);
        checkFrame("ovfFirst", base, 8'hA5, 8'h00, 8'h00, 8'h00);
        checkFrame("ovfLast", base + 60, 8'hA5, 8'h00, 8'h0F, 8'h0F);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("ovfCleared", overflow, 0);

        $display("[TB] ack timeout with txBusy held low");
        ackEnabled = 1'b0;
        base = sendCount;
        applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        waitSends(base + 3, 200);
        checkOutput("retryPeriod", lastSendCycle - prevSendCycle, 16);
        if (sendLog.size() >= base + 3) begin
            checkOutput("retryData1", sendLog[base + 1], 8'hA5);
            checkOutput("retryData2", sendLog[base + 2], 8'hA5);
        end else begin
            checkOutput("retryLen", sendLog.size(), base + 3);
        end
        @(negedge clk);
        ackEnabled = 1'b1;
        waitSends(base + 7, 300);
        waitIdle(100);
        checkFrame("retryTail", base + 3, 8'hA5, 8'hBE, 8'hEF, 8'h51);

        $display("[TB] simultaneous push/pop at 15 entries, txErr and clearFlags");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, 1'b0);
        end
        base = sendCount;
        applyStimulus(1'b1, 16'h0200, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("pushPopCount", fifoCount, 15);
        checkOutput("pushPopNoOvf", overflow, 0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        waitSends(base + 2, 200);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("errFault", txFault, 1);
        waitSends(base + 4, 200);
        checkFrame("errFrame", base, 8'hA5, 8'h01, 8'h00, 8'h01);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("faultCleared", txFault, 0);
        waitSends(base + 6, 200);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("setBeatsClear", txFault, 1);
        waitSends(base + 64, 3000);
        waitIdle(100);
        checkOutput("pushPopDrained", fifoCount, 0);
        checkFrame("pushPopLast", base + 60, 8'hA5, 8'h02, 8'h00, 8'h02);

        $display("[TB] reset during byte 2 of a frame");
        base = sendCount;
        applyStimulus(1'b1, 16'h0A0B, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0C0D, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0E0F, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        waitSends(base + 2, 200);
        @(negedge clk);
        #2 rstb = 1'b0;
        #1;
        checkOutput("midRstTxSend", txSend, 0);
        checkOutput("midRstTxData", txData, 0);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstCount", fifoCount, 0);
        checkOutput("midRstOverflow", overflow, 0);
        checkOutput("midRstTxFault", txFault, 0);
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        checkOutput("postRstSends", sendCount - base, 2);
        checkOutput("postRstBusy", busy, 0);
        base = sendCount;
        applyStimulus(1'b1, 16'h00FF, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        waitSends(base + 4, 200);
        waitIdle(100);
        checkFrame("postRstFrame", base, 8'hA5, 8'h00, 8'hFF, 8'hFF);

        $display("[TB] txErr while idle");
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("idleErrNoFault", txFault, 0);
        repeat (5) @(posedge clk);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
